// File: rtl/gate_truth_table_checker.sv
// Stimulus/response checker for a 2-input gate: applies {in2,in1} = 00,01,10,11 and compares samples
// against EXPECTED_TT. Define GATE_CHECK_HALT_ON_FAIL_EN to stop the run at the first mismatch.
module gate_truth_table_checker #(
  parameter int unsigned SETTLE_CYCLES = 7,
  parameter logic [3:0]  EXPECTED_TT   = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] vec_idx
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          mism;
  logic          halt;
  logic [3:0]    mask_next;

  // Mask including the sample taken this cycle, so pass reflects the final vector too.
  always_comb begin
    mism               = gate_out ^ EXPECTED_TT[vec_idx];
    mask_next          = fail_mask;
    mask_next[vec_idx] = mism;
`ifdef GATE_CHECK_HALT_ON_FAIL_EN
    halt = mism;
`else
    halt = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in1       <= 1'b0;
      in2       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      vec_idx   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            cnt       <= '0;
            in1       <= 1'b0;
            in2       <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            vec_idx   <= '0;
          end
        end
        DRIVE: begin
          if (cnt == LAST) begin
            fail_mask <= mask_next;
            if (vec_idx == 2'd3 || halt) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= ~|mask_next;
            end else begin
              vec_idx    <= vec_idx + 2'd1;
              {in2, in1} <= vec_idx + 2'd1;
              cnt        <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Randomized bench: gate models are truth tables; results predicted from mismatch = gate ^ expected.
module tb_gate_truth_table_checker;

  logic clk = 1'b0;
  logic rst;
  logic st;
  logic sel;
  logic noise0;
  logic [3:0] tt0, tt1;

  logic start0, start1, gate_out0, gate_out1;
  logic in1_0, in2_0, busy0, done0, pass0, in1_1, in2_1, busy1, done1, pass1;
  logic [3:0] fail_mask0, fail_mask1;
  logic [1:0] vec_idx0, vec_idx1;

  logic obs_in1, obs_in2, obs_busy, obs_done, obs_pass;
  logic [3:0] obs_mask;
  logic [1:0] obs_idx;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  assign start0    = st & ~sel;
  assign start1    = st & sel;
  assign gate_out0 = tt0[{in2_0, in1_0}] ^ noise0;
  assign gate_out1 = tt1[{in2_1, in1_1}];

  assign obs_in1  = sel ? in1_1 : in1_0;
  assign obs_in2  = sel ? in2_1 : in2_0;
  assign obs_busy = sel ? busy1 : busy0;
  assign obs_done = sel ? done1 : done0;
  assign obs_pass = sel ? pass1 : pass0;
  assign obs_mask = sel ? fail_mask1 : fail_mask0;
  assign obs_idx  = sel ? vec_idx1 : vec_idx0;

  gate_truth_table_checker dut (
    .clk(clk), .rst(rst), .start(start0), .gate_out(gate_out0),
    .in1(in1_0), .in2(in2_0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_mask(fail_mask0), .vec_idx(vec_idx0)
  );

  gate_truth_table_checker #(.SETTLE_CYCLES(1), .EXPECTED_TT(4'b0111)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .gate_out(gate_out1),
    .in1(in1_1), .in2(in2_1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_mask(fail_mask1), .vec_idx(vec_idx1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // u selects the DUT (0: S=7/AND table, 1: S=1/NAND table); g is the gate's truth table.
  task automatic run(input logic u, input int unsigned s, input logic [3:0] e,
                     input logic [3:0] g, input bit inject);
    logic [3:0] mism, emask;
    int unsigned elen, eidx, busy_cnt, c;
    int done_at;
    bit found;

    mism  = g ^ e;
    emask = mism;
    elen  = 4 * s;
    eidx  = 3;
`ifdef GATE_CHECK_HALT_ON_FAIL_EN
    found = 0;
    emask = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (!found && mism[k]) begin
        found = 1;
        emask = 4'b0001 << k;
        elen  = (k + 1) * s;
        eidx  = k;
      end
    end
`else
    found = (mism != 0);
`endif

    @(negedge clk);
    sel = u;
    if (u) tt1 = g; else tt0 = g;
    noise0 = 1'b0;
    st = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st = 1'b0;
    check("cleared_at_start", {31'd0, obs_done} | {28'd0, obs_mask}, 32'd0);

    busy_cnt = 0;
    done_at  = -1;
    c        = 0;
    while (c <= 4 * s + 4) begin
      if (obs_busy) busy_cnt++;
      if (obs_done) begin
        done_at = c;
        break;
      end
      c++;
      noise0 = (!u && (c % s) != 0) ? logic'($urandom_range(1, 0)) : 1'b0;
      st     = (inject && c == 3);
      @(posedge clk);
      @(negedge clk);
    end
    noise0 = 1'b0;
    st     = 1'b0;

    check("latency", done_at, elen);
    check("busy_cycles", busy_cnt, elen);
    check("busy_low", obs_busy, 1'b0);
    check("fail_mask", obs_mask, emask);
    check("pass", obs_pass, (emask == 4'b0000));
    check("vec_idx", obs_idx, eidx[1:0]);
    check("inputs_held", {obs_in2, obs_in1}, eidx[1:0]);
    if (found && emask == 4'b0000) check("model_consistency", 1, 0);
  endtask

  initial begin
    rst = 1'b1; st = 1'b0; sel = 1'b0; noise0 = 1'b0;
    tt0 = 4'b1000; tt1 = 4'b0111;
    #1;
    check("reset_state", {in2_0, in1_0, busy0, done0, pass0, fail_mask0, vec_idx0}, 0);
    @(negedge clk);
    rst = 1'b0;

    run(0, 7, 4'b1000, 4'b1000, 0);  // AND
    run(0, 7, 4'b1000, 4'b1110, 0);  // OR
    run(1, 1, 4'b0111, 4'b0111, 0);  // NAND
    run(1, 1, 4'b0111, 4'b1000, 0);  // AND vs NAND table

    // Reset mid-run.
    @(negedge clk);
    sel = 0; tt0 = 4'b1000; st = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("mid_run_reset", {in2_0, in1_0, busy0, done0, pass0, fail_mask0, vec_idx0}, 0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 7, 4'b1000, 4'b1000, 0);

    // start while busy ignored; rerun from DONE.
    run(0, 7, 4'b1000, 4'b1000, 1);
    run(0, 7, 4'b1000, 4'b1110, 1);

    // rst and start together: rst wins.
    @(negedge clk);
    sel = 0; rst = 1'b1; st = 1'b1;
    @(posedge clk);
    #1 check("rst_beats_start", {busy0, done0, fail_mask0}, 0);
    @(negedge clk);
    rst = 1'b0; st = 1'b0;
    @(negedge clk);
    check("idle_after_rst", busy0, 1'b0);

    for (int i = 0; i < 8; i++) run(0, 7, 4'b1000, 4'($urandom), (i % 3) == 1);
    for (int i = 0; i < 6; i++) run(1, 1, 4'b0111, 4'($urandom), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
